gray_stream_decoder: RTL

Downstream consumer of the binary-to-gray stage. Accepts a stream of gray-coded samples (counter or encoder positions) with a valid strobe. Converts each sample back to binary through a 2-stage pipeline and checks that consecutive samples obey the single-bit-change rule. Reports direction, step errors and lock status to the control logic.

---
 rtl/gray_stream_decoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/gray_stream_decoder.sv
// Gray-coded sample stream decoder: 2-stage gray->binary pipeline with
// single-bit-step checking, direction flags, error counting and lock FSM.
module gray_stream_decoder #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_valid,
    input  logic                 clr,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 dir_up,
    output logic                 dir_down,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 locked
);

    typedef enum logic [1:0] {SEARCH, TRACK, FAULT} state_t;

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       g1_reg;
    logic                   v1_reg;
    logic [WIDTH-1:0]       last_gray_reg, last_bin_reg;
    logic [3:0]             consec_reg, consec_next, consec_inc;
    logic [ERR_CNT_W-1:0]   err_count_next;
    logic                   up_next, down_next, err_next;

    logic [WIDTH-1:0]       bin1;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH-1:0]       bin_delta;
    logic                   diff_zero, diff_one;

    // Each binary bit is the XOR of all gray bits at and above it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign bin1[gi] = ^g1_reg[WIDTH-1:gi];
        end
    endgenerate

    assign diff      = g1_reg ^ last_gray_reg;
    assign diff_zero = (diff == '0);
    assign diff_one  = !diff_zero && ((diff & (diff - 1'b1)) == '0);
    assign bin_delta = bin1 - last_bin_reg;
    assign consec_inc = (consec_reg == 4'hF) ? consec_reg : consec_reg + 4'd1;

    always_comb begin
        state_next     = state_reg;
        consec_next    = consec_reg;
        err_count_next = err_count;
        up_next        = 1'b0;
        down_next      = 1'b0;
        err_next       = 1'b0;
        if (clr) begin
            state_next     = SEARCH;
            consec_next    = '0;
            err_count_next = '0;
        end else if (v1_reg) begin
            if (state_reg == SEARCH) begin
                // First sample after reset/clear only seeds the history.
                state_next  = TRACK;
                consec_next = '0;
            end else if (!diff_zero && !diff_one) begin
                err_next    = 1'b1;
                consec_next = consec_inc;
                if (!(&err_count))
                    err_count_next = err_count + 1'b1;
                if (state_reg == TRACK && consec_inc >= 4'(ERR_LIMIT))
                    state_next = FAULT;
            end else begin
                consec_next = '0;
                if (diff_one) begin
                    up_next   = (bin_delta == WIDTH'(1));
                    down_next = (bin_delta != WIDTH'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= SEARCH;
            g1_reg        <= '0;
            v1_reg        <= 1'b0;
            last_gray_reg <= '0;
            last_bin_reg  <= '0;
            consec_reg    <= '0;
            err_count     <= '0;
            bin_out       <= '0;
            bin_valid     <= 1'b0;
            dir_up        <= 1'b0;
            dir_down      <= 1'b0;
            step_err      <= 1'b0;
            locked        <= 1'b0;
        end else begin
            v1_reg     <= gray_valid && !clr;
            if (gray_valid && !clr)
                g1_reg <= gray_in;
            state_reg  <= state_next;
            consec_reg <= consec_next;
            err_count  <= err_count_next;
            bin_valid  <= v1_reg && !clr;
            dir_up     <= up_next;
            dir_down   <= down_next;
            step_err   <= err_next;
            locked     <= (state_next == TRACK);
            if (v1_reg && !clr) begin
                bin_out       <= bin1;
                last_gray_reg <= g1_reg;
                last_bin_reg  <= bin1;
            end
        end
    end

endmodule
